watermark_pixel_writer: RTL and testbench

WATERMARK_PIXEL_WRITER -- requirements
Module: watermark_pixel_writer

---
 rtl/wm_pkg.sv | 17 +
 rtl/wm_word_fifo.sv | 59 +++++
 rtl/watermark_pixel_writer.sv | 163 ++++++++++++++++
 tb/tb_watermark_pixel_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared types and default widths for the watermark pixel writer.
// Optional checksum output is enabled by WM_WRITER_CHECKSUM_EN.
package wm_pkg;

   localparam int WM_AMBA_WORD  = 16;
   localparam int WM_ADDR_DEPTH = 20;
   localparam int WM_DATA_DEPTH = 8;
   localparam int WM_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PACK,
      ST_FLUSH,
      ST_DONE
   } wm_state_e;

endpackage

// File: rtl/wm_word_fifo.sv
// Synchronous word FIFO; a push while full succeeds only alongside a pop.
// Depth must be a power of two, at least 2.
module wm_word_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = mem_q[rptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (do_pop)
            rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/watermark_pixel_writer.sv
// Packs watermarked pixels into word pairs and streams them to the output bank.
// Define WM_WRITER_CHECKSUM_EN to add a per-frame checksum output.
module watermark_pixel_writer
   import wm_pkg::*;
#(
   parameter int          Amba_Word       = WM_AMBA_WORD,
   parameter int          Amba_Addr_Depth = WM_ADDR_DEPTH,
   parameter int          Data_Depth      = WM_DATA_DEPTH,
   parameter int          Fifo_Depth      = WM_FIFO_DEPTH,
   parameter int unsigned Base_Addr       = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       new_pixel,
   input  logic [Data_Depth-1:0]      Pixel_Data,
   input  logic                       Image_Done,
   output logic                       wr_valid,
   input  logic                       wr_ready,
   output logic [Amba_Addr_Depth:0]   wr_addr,
   output logic [Amba_Word-1:0]       wr_data,
   output logic                       frame_done,
   output logic                       overflow
`ifdef WM_WRITER_CHECKSUM_EN
   ,
   output logic [Amba_Word-1:0]       checksum
`endif
);

   localparam int AW = Amba_Addr_Depth + 1;
   localparam logic [AW-1:0] BASE = AW'(Base_Addr);

   wm_state_e state_q, state_d;

   logic [Data_Depth-1:0]    hold_q, hold_d;
   logic                     half_q, half_d;
   logic                     ovf_q, ovf_d;
   logic [AW-1:0]            addr_q, addr_d;

   logic                     accept, start, fin;
   logic                     push, pop, drop;
   logic [Amba_Word-1:0]     push_word, head;
   logic                     fifo_full, fifo_empty;
   logic [$clog2(Fifo_Depth):0] fifo_cnt;

   wm_word_fifo #(
      .W     (Amba_Word),
      .DEPTH (Fifo_Depth)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (push),
      .data_i  (push_word),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         half_q  <= 1'b0;
         ovf_q   <= 1'b0;
         addr_q  <= BASE;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         half_q  <= half_d;
         ovf_q   <= ovf_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (new_pixel)
               state_d = Image_Done ? ST_FLUSH : ST_PACK;
         ST_PACK:
            if (Image_Done)
               state_d = ST_FLUSH;
         ST_FLUSH:
            if (fifo_cnt == '0)
               state_d = ST_DONE;
         ST_DONE:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // A frame-ending pixel is packed first; a lone half goes out zero-padded.
   always_comb begin
      accept    = new_pixel &&
                  (state_q == ST_IDLE || state_q == ST_PACK);
      start     = new_pixel && (state_q == ST_IDLE);
      fin       = Image_Done && (state_q == ST_PACK || start);
      push      = 1'b0;
      push_word = '0;
      if (accept && half_q) begin
         push      = 1'b1;
         push_word = {Pixel_Data, hold_q};
      end else if (fin && accept) begin
         push      = 1'b1;
         push_word = {{Data_Depth{1'b0}}, Pixel_Data};
      end else if (fin && half_q) begin
         push      = 1'b1;
         push_word = {{Data_Depth{1'b0}}, hold_q};
      end
      pop        = !fifo_empty && wr_ready;
      drop       = push && fifo_full && !pop;
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      hold_d = hold_q;
      half_d = half_q;
      if (fin) begin
         hold_d = '0;
         half_d = 1'b0;
      end else if (accept) begin
         half_d = ~half_q;
         if (!half_q)
            hold_d = Pixel_Data;
      end
      ovf_d = start ? 1'b0 : (ovf_q | drop);
      addr_d = addr_q;
      if (state_q == ST_DONE)
         addr_d = BASE;
      else if (pop)
         addr_d = addr_q + 1'b1;
   end

   assign wr_valid = !fifo_empty;
   assign wr_data  = fifo_empty ? '0 : head;
   assign wr_addr  = addr_q;
   assign overflow = ovf_q;

`ifdef WM_WRITER_CHECKSUM_EN
   logic [Amba_Word-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (start)
         sum_d = '0;
      else if (pop)
         sum_d = sum_q + wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_watermark_pixel_writer.sv
// Scoreboard bench for watermark_pixel_writer: directed frames, overflow,
// mid-frame reset and (with WM_WRITER_CHECKSUM_EN) the checksum.
module tb_watermark_pixel_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_pixel;
   logic [7:0]  Pixel_Data;
   logic        Image_Done;
   logic        wr_valid;
   logic        wr_ready;
   logic [20:0] wr_addr;
   logic [15:0] wr_data;
   logic        frame_done;
   logic        overflow;
`ifdef WM_WRITER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int tests = 0;
   int fails = 0;
   int fd_cnt = 0;
   logic [36:0] exp_q [$];
   logic        ck_en = 1'b0;
   logic [15:0] ck_exp = '0;

   watermark_pixel_writer dut (
      .clk        (clk),
      .rst        (rst),
      .new_pixel  (new_pixel),
      .Pixel_Data (Pixel_Data),
      .Image_Done (Image_Done),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .overflow   (overflow)
`ifdef WM_WRITER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted transfer against the scoreboard.
   always @(negedge clk) begin
      if (rst && frame_done) begin
         fd_cnt++;
`ifdef WM_WRITER_CHECKSUM_EN
         if (ck_en)
            check("checksum", {16'h0, checksum}, {16'h0, ck_exp});
`endif
      end
      if (rst && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {11'h0, wr_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wr_addr", {11'h0, wr_addr}, {11'h0, e[36:16]});
            check("wr_data", {16'h0, wr_data}, {16'h0, e[15:0]});
         end
      end
   end

   task automatic expect_word(input logic [20:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic px(input logic [7:0] p, input logic done);
      new_pixel  = 1'b1;
      Pixel_Data = p;
      Image_Done = done;
      @(posedge clk); #1;
      new_pixel  = 1'b0;
      Image_Done = 1'b0;
   endtask

   task automatic idone();
      Image_Done = 1'b1;
      @(posedge clk); #1;
      Image_Done = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int fd0;
      bit seen;
      fd0  = fd_cnt;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         if (fd_cnt != fd0) seen = 1;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, "_frame_done_pulses"}, fd_cnt - fd0, 1);
      check({name, "_scoreboard_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      rst        = 1'b0;
      new_pixel  = 1'b0;
      Pixel_Data = '0;
      Image_Done = 1'b0;
      wr_ready   = 1'b1;
      #12;
      check("rst_wr_valid", {31'h0, wr_valid}, 0);
      check("rst_wr_addr", {11'h0, wr_addr}, 0);
      check("rst_wr_data", {16'h0, wr_data}, 0);
      check("rst_frame_done", {31'h0, frame_done}, 0);
      check("rst_overflow", {31'h0, overflow}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic frame of four pixels
      expect_word(21'd0, 16'h2211);
      expect_word(21'd1, 16'h4433);
      px(8'h11, 0);
      check("no_valid_after_one_pixel", {31'h0, wr_valid}, 0);
      px(8'h22, 0);
      check("latency_wr_valid", {31'h0, wr_valid}, 1);
      px(8'h33, 0);
      px(8'h44, 0);
      idone();
      wait_frame("quad");

      // Odd pixel count, Image_Done with the last pixel
      expect_word(21'd0, 16'hBBAA);
      expect_word(21'd1, 16'h00CC);
      px(8'hAA, 0);
      px(8'hBB, 0);
      px(8'hCC, 1);
      wait_frame("odd");

      // Stalled output: only four words fit, the rest are dropped
      wr_ready = 1'b0;
      for (int i = 1; i <= 12; i++)
         px(8'(i), 0);
      check("ovf_set", {31'h0, overflow}, 1);
      check("ovf_head_stable", {16'h0, wr_data}, 32'h0201);
      check("ovf_valid", {31'h0, wr_valid}, 1);
      expect_word(21'd0, 16'h0201);
      expect_word(21'd1, 16'h0403);
      expect_word(21'd2, 16'h0605);
      expect_word(21'd3, 16'h0807);
      wr_ready = 1'b1;
      idone();
      wait_frame("ovf");
      check("ovf_sticky", {31'h0, overflow}, 1);

      // Push and pop together while full: nothing dropped
      wr_ready = 1'b0;
      px(8'h01, 0);
      check("ovf_cleared_new_frame", {31'h0, overflow}, 0);
      for (int i = 2; i <= 9; i++)
         px(8'(i), 0);
      expect_word(21'd0, 16'h0201);
      expect_word(21'd1, 16'h0403);
      expect_word(21'd2, 16'h0605);
      expect_word(21'd3, 16'h0807);
      expect_word(21'd4, 16'h0A09);
      wr_ready = 1'b1;
      px(8'h0A, 0);
      check("full_push_pop_no_ovf", {31'h0, overflow}, 0);
      idone();
      wait_frame("fullpp");
      check("fullpp_ovf_end", {31'h0, overflow}, 0);

      // Reset mid-frame with a word buffered and a pixel held
      wr_ready = 1'b0;
      px(8'h31, 0);
      px(8'h32, 0);
      px(8'h33, 0);
      check("pre_reset_valid", {31'h0, wr_valid}, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_valid", {31'h0, wr_valid}, 0);
      check("async_rst_addr", {11'h0, wr_addr}, 0);
      @(posedge clk); #1;
      rst      = 1'b1;
      wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_idle", {31'h0, wr_valid}, 0);
      expect_word(21'd0, 16'h6655);
      px(8'h55, 0);
      px(8'h66, 1);
      wait_frame("post_rst");

`ifdef WM_WRITER_CHECKSUM_EN
      ck_exp = 16'h0001;
      ck_en  = 1'b1;
      expect_word(21'd0, 16'hFFFF);
      expect_word(21'd1, 16'h0002);
      px(8'hFF, 0);
      px(8'hFF, 0);
      px(8'h02, 0);
      px(8'h00, 1);
      wait_frame("cksum");
      ck_en = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
